// File: rtl/snn_spi_host.sv
// snn_spi_host: SPI mode-0 initiator that shifts one fixed-length frame per command, MSB first.
// Optional feature macro SNN_SPI_HOST_BURST_EN chains back-to-back frames under one cs_n assertion.
module snn_spi_host #(
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [FRAME_BITS-1:0] i_cmd_data,
  output logic                  o_rsp_valid,
  output logic [FRAME_BITS-1:0] o_rsp_data,
  output logic                  o_busy,
  output logic                  o_sclk,
  output logic                  o_cs_n,
  output logic                  o_copi,
  input  logic                  i_cipo
);

  localparam int unsigned BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEAD  = 3'd1;
  localparam logic [2:0] ST_LOW   = 3'd2;
  localparam logic [2:0] ST_HIGH  = 3'd3;
  localparam logic [2:0] ST_TRAIL = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [7:0]            r_div;
  logic [BIT_W-1:0]      r_bit;
  logic [FRAME_BITS-1:0] r_tx;
  logic [FRAME_BITS-1:0] r_rx;
  logic [FRAME_BITS-1:0] r_rsp_data;
  logic                  r_rsp_valid;
  logic                  w_div_last;
  logic                  w_bit_last;
  logic                  w_burst_ok;
  logic                  w_hs;

  assign w_div_last = (r_div == 8'(CLK_DIV - 1));
  assign w_bit_last = (r_bit == BIT_W'(FRAME_BITS - 1));

`ifdef SNN_SPI_HOST_BURST_EN
  assign w_burst_ok = (r_state == ST_TRAIL) && w_div_last;
`else
  assign w_burst_ok = 1'b0;
`endif

  assign o_cmd_ready = (r_state == ST_IDLE) || w_burst_ok;
  assign w_hs        = i_cmd_valid && o_cmd_ready;

  assign o_cs_n      = (r_state == ST_IDLE) || (r_state == ST_GAP);
  assign o_sclk      = (r_state == ST_HIGH);
  assign o_copi      = !o_cs_n && r_tx[FRAME_BITS-1];
  assign o_busy      = (r_state != ST_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_hs) w_state_nxt = ST_LEAD;
      ST_LEAD:  if (w_div_last) w_state_nxt = ST_HIGH;
      ST_HIGH:  if (w_div_last) w_state_nxt = w_bit_last ? ST_TRAIL : ST_LOW;
      ST_LOW:   if (w_div_last) w_state_nxt = ST_HIGH;
      ST_TRAIL: if (w_div_last) w_state_nxt = w_hs ? ST_LEAD : ST_GAP;
      ST_GAP:   if (w_div_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_div       <= 8'd0;
      r_bit       <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= (w_state_nxt != r_state) ? 8'd0 : r_div + 8'd1;
      r_rsp_valid <= 1'b0;

      if (w_hs) begin
        r_tx  <= i_cmd_data;
        r_bit <= '0;
      end

      // cipo is sampled at the end of the high phase, tolerating a late target.
      if ((r_state == ST_HIGH) && w_div_last) begin
        r_rx <= {r_rx[FRAME_BITS-2:0], i_cipo};
        if (!w_bit_last) r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
      end

      if ((r_state == ST_LOW) && w_div_last) r_bit <= r_bit + 1'b1;

      if ((r_state == ST_TRAIL) && w_div_last) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= r_rx;
      end
    end
  end

endmodule

// File: doc/snn_spi_host.md
# snn_spi_host

SPI mode-0 initiator that drives the SNN core's configuration port from the controller side: it generates `sclk`, `cs_n` and `copi`, and captures `cipo`. Each accepted command is shifted out MSB-first as one fixed-length frame, while the target's reply bits are shifted in. The block sits in the test/bring-up harness, or in a host FPGA, and programs weights and thresholds over the same 4-wire link the SNN top exposes.

## Interface
- `FRAME_BITS`, default 16: bits per frame (command + data); legal range 2..32.
- `CLK_DIV`, default 4: `sclk` half-period in `clk` cycles; legal range 1..255. 0 is illegal.
- `clk` input 1: single system clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: a command is presented.
- `cmd_ready` output 1: the host accepts `cmd_data` on a cycle where `cmd_valid && cmd_ready`.
- `cmd_data` input FRAME_BITS: frame to transmit, MSB first.
- `rsp_valid` output 1: one-cycle pulse; `rsp_data` holds the captured frame.
- `rsp_data` output FRAME_BITS: bits sampled from `cipo`, MSB first. Holds its value until the next pulse.
- `busy` output 1: high whenever the state is not IDLE.
- `sclk` output 1: SPI clock; idles low (CPOL=0).
- `cs_n` output 1: chip select, active low.
- `copi` output 1: controller-out data.
- `cipo` input 1: controller-in data.

## Operation
- **States:** IDLE, LEAD, LOW, HIGH, TRAIL, GAP. A divider counter counts 0..CLK_DIV-1 and is cleared on every state change.
- **IDLE:** `cs_n`=1, `sclk`=0, `cmd_ready`=1.
  - On handshake: latch `cmd_data` into the TX shift register, clear the bit counter, go to LEAD.
- **LEAD:** `cs_n`=0, `copi`=TX[FRAME_BITS-1]. Lasts CLK_DIV cycles, then go to HIGH.
- **HIGH:** `sclk`=1 for CLK_DIV cycles.
  - On the final cycle's edge: shift `cipo` into the RX LSB, and drop `sclk`.
  - If the bit counter is FRAME_BITS-1, go to TRAIL. Otherwise go to LOW and shift TX left, so `copi` presents the next bit.
- **LOW:** `sclk`=0 for CLK_DIV cycles, then go to HIGH and increment the bit counter.
- **TRAIL:** `cs_n`=0, `sclk`=0 for CLK_DIV cycles.
  - On exit: `cs_n`→1, `rsp_data`←RX, `rsp_valid`=1 for exactly one cycle, go to GAP.
- **GAP:** `cs_n`=1 for CLK_DIV cycles, then go to IDLE.
- **`cmd_ready`:** low in every state except IDLE (and the burst case below). `cmd_data` is ignored unless a handshake occurs.
- **`copi`:** 0 whenever `cs_n`=1. After the last bit, `copi` holds the LSB through TRAIL.
- **`cipo`:** sampled only at the end of HIGH. This tolerates target output delay of up to one half-period. No synchronizer is included; the target must be clocked by this `sclk`.
- **Reset, asserted anytime including mid-frame:** immediately `cs_n`=1, `sclk`=0, `copi`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0, state=IDLE. A partially sent frame is abandoned with no response.

## Timing
- Handshake at cycle 0 → `cs_n` low from cycle 1.
- First `sclk` rise at cycle 1+CLK_DIV.
- `cs_n` stays low for (2·FRAME_BITS+1)·CLK_DIV cycles: LEAD + FRAME_BITS HIGH phases + (FRAME_BITS-1) LOW phases + TRAIL.
- `rsp_valid` is asserted on the cycle `cs_n` first reads 1.
- `cmd_ready` returns CLK_DIV cycles after `rsp_valid`.
- Non-burst throughput: one frame per (2·FRAME_BITS+2)·CLK_DIV+1 cycles.
- `copi` changes only on the same `clk` edge that `sclk` falls (or on LEAD entry), so it is stable ≥CLK_DIV cycles before each rising `sclk`.

## Configuration
- **`SNN_SPI_HOST_BURST_EN` defined:**
  - On the last TRAIL cycle `cmd_ready`=1.
  - If `cmd_valid` is high that cycle, the new command is latched, `rsp_valid` still pulses, `cs_n` stays low, and the state goes directly to LEAD (GAP skipped).
  - Back-to-back frames therefore share one `cs_n` assertion.
- **Undefined:** `cmd_ready` is low in TRAIL, and every frame is framed by its own `cs_n` and GAP.

## Test plan
- **Single frame:** CLK_DIV=2, FRAME_BITS=16, `cmd_data`=0xA5C3, target model replies 0x3C5A → `copi` sequence is 1010_0101_1100_0011 on rising `sclk`; `rsp_data`=0x3C5A; `cs_n` low for 66 cycles; `rsp_valid` is a 1-cycle pulse.
- **Divider edge:** CLK_DIV=1, FRAME_BITS=8, cmd 0xFF, reply 0x00 → `sclk` period 2 cycles; 8 rising edges; `cs_n` low 17 cycles; `rsp_data`=0x00.
- **Back-pressure:** `cmd_valid` held high with changing `cmd_data` during a frame → only the IDLE-cycle value is sent; the next frame starts exactly 2·FRAME_BITS·CLK_DIV+2·CLK_DIV+1 cycles after the first handshake.
- **Mid-frame reset:** assert `rst_n`=0 after 5 bits → same cycle `cs_n`=1, `sclk`=0, `copi`=0, `busy`=0; no `rsp_valid`; after release a new 0x1234 frame completes correctly.
- **Burst (macro on):** two commands 0x0001 and 0x8000 with `cmd_valid` continuous → `cs_n` never rises between frames; two `rsp_valid` pulses. With the macro off → `cs_n` is high for CLK_DIV+1 cycles between frames.
- **Late `cipo`:** target drives `cipo` CLK_DIV-1 cycles after `sclk` rises → captured data is still correct.
